// File: rtl/fifo320_arb_pkg.sv
// Shared types and constants for the fifo320 write-side arbiters.
package fifo320_arb_pkg;

   localparam int FIFO320_DATA_W = 320;

   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t XFER = 1'b1;

   // Widest grant index any fifo320 arbiter needs (up to 8 ports).
   localparam int PID_MAX_W = 3;
   typedef logic [PID_MAX_W-1:0] pid_t;

   function automatic int pid_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo320_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo N.
module fifo320_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic         any_o,
   output logic [W-1:0] idx_o
);

   // Scan farthest-first so the nearest requester after last_i wins.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      for (int i = N; i >= 1; i--) begin
         if (req_i[(int'(last_i) + i) % N]) begin
            any_o = 1'b1;
            idx_o = W'((int'(last_i) + i) % N);
         end
      end
   end

endmodule

// File: rtl/fifo320_wr_arb.sv
// Packet-level round-robin write arbiter sharing one fifo320 among NUM_PORTS lanes.
// Optional per-port packet counters with FIFO320_WR_ARB_STATS_EN.
module fifo320_wr_arb
   import fifo320_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = FIFO320_DATA_W,
   parameter int PID_W     = pid_width(NUM_PORTS)
) (
   input  logic                        clock,
   input  logic                        sclr,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   input  logic [NUM_PORTS-1:0]        in_valid,
   input  logic [NUM_PORTS-1:0]        in_sop,
   input  logic [NUM_PORTS-1:0]        in_eop,
   output logic [NUM_PORTS-1:0]        in_ready,
   output logic [DATA_W-1:0]           fifo_data,
   output logic                        fifo_wrreq,
   input  logic                        fifo_full,
   output logic [PID_W-1:0]            grant_id,
   output logic                        busy,
   output logic [NUM_PORTS-1:0]        err_nosop,
   output logic                        err_sop,
   output logic [NUM_PORTS*32-1:0]     pkt_cnt
);

   state_t               state_q, state_d;
   logic [PID_W-1:0]     grant_q, grant_d;
   logic [PID_W-1:0]     last_q, last_d;
   logic                 first_q, first_d;
   logic [NUM_PORTS-1:0] err_nosop_q, err_nosop_d;
   logic                 err_sop_q, err_sop_d;

   logic                 pick_any;
   logic [PID_W-1:0]     pick_idx;
   logic                 g_valid, g_sop, g_eop, accept;

   fifo320_rr_pick #(.N(NUM_PORTS), .W(PID_W)) u_pick (
      .req_i  (in_valid & in_sop),
      .last_i (last_q),
      .any_o  (pick_any),
      .idx_o  (pick_idx)
   );

   assign g_valid = in_valid[grant_q];
   assign g_sop   = in_sop[grant_q];
   assign g_eop   = in_eop[grant_q];
   assign accept  = (state_q == XFER) && fifo_wrreq;

   // Non-sop beats seen while idle are acknowledged so the lane can flush them.
   always_comb begin
      in_ready   = '0;
      fifo_wrreq = 1'b0;
      fifo_data  = '0;
      if (!sclr) begin
         if (state_q == IDLE) begin
            in_ready = in_valid & ~in_sop;
         end else begin
            in_ready[grant_q] = ~fifo_full;
            fifo_wrreq        = g_valid & ~fifo_full;
            fifo_data         = in_data[int'(grant_q)*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      first_d     = first_q;
      err_nosop_d = '0;
      err_sop_d   = 1'b0;
      if (state_q == IDLE) begin
         err_nosop_d = in_valid & ~in_sop;
         if (pick_any) begin
            state_d = XFER;
            grant_d = pick_idx;
            first_d = 1'b1;
         end
      end else if (accept) begin
         first_d   = 1'b0;
         err_sop_d = g_sop & ~first_q;
         if (g_eop) begin
            state_d = IDLE;
            last_d  = grant_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         last_q      <= PID_W'(NUM_PORTS - 1);
         first_q     <= 1'b0;
         err_nosop_q <= '0;
         err_sop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         first_q     <= first_d;
         err_nosop_q <= err_nosop_d;
         err_sop_q   <= err_sop_d;
      end
   end

   assign grant_id  = grant_q;
   assign busy      = (state_q == XFER);
   assign err_nosop = err_nosop_q;
   assign err_sop   = err_sop_q;

`ifdef FIFO320_WR_ARB_STATS_EN
   logic [31:0] cnt_q [NUM_PORTS];

   always_ff @(posedge clock) begin
      if (sclr) begin
         for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else if (accept && g_eop) begin
         cnt_q[grant_q] <= cnt_q[grant_q] + 32'd1;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
      assign pkt_cnt[p*32 +: 32] = cnt_q[p];
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo320_wr_arb.sv
// Directed bench for fifo320_wr_arb (2 ports): arbitration, stalls, error pulses, reset, counters.
module tb_fifo320_wr_arb;

   localparam int NP = 2;
   localparam int DW = 320;
`ifdef FIFO320_WR_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             sclr;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]    in_valid, in_sop, in_eop, in_ready;
   logic [DW-1:0]    fifo_data;
   logic             fifo_wrreq, fifo_full;
   logic             grant_id;
   logic             busy;
   logic [NP-1:0]    err_nosop;
   logic             err_sop;
   logic [NP*32-1:0] pkt_cnt;

   int tests = 0;
   int fails = 0;

   fifo320_wr_arb #(.NUM_PORTS(NP), .DATA_W(DW), .PID_W(1)) dut (
      .clock      (clock),
      .sclr       (sclr),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_ready   (in_ready),
      .fifo_data  (fifo_data),
      .fifo_wrreq (fifo_wrreq),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy),
      .err_nosop  (err_nosop),
      .err_sop    (err_sop),
      .pkt_cnt    (pkt_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic beat(input int p, input logic v, input logic s, input logic e, input logic [63:0] d);
      in_valid[p] = v;
      in_sop[p]   = s;
      in_eop[p]   = e;
      in_data[p*DW +: DW] = {256'd0, d};
   endtask

   task automatic idle_all();
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      in_data  = '0;
   endtask

   task automatic chk_wr(input string tag, input logic [63:0] d);
      chk({tag, "_wrreq"}, 64'(fifo_wrreq), 64'd1);
      chk({tag, "_data"}, fifo_data[63:0], d);
      chk({tag, "_data_hi"}, 64'(|fifo_data[DW-1:64]), 64'd0);
   endtask

   initial begin
      idle_all();
      fifo_full = 1'b0;
      sclr      = 1'b1;
      tick();
      // Outputs stay quiet while sclr is held, even with valid non-sop beats.
      beat(0, 1'b1, 1'b0, 1'b0, 64'h11);
      beat(1, 1'b1, 1'b0, 1'b0, 64'h22);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_err_nosop", 64'(err_nosop), 64'd0);
      chk("rst_err_sop", 64'(err_sop), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      tick();
      idle_all();
      sclr = 1'b0;

      // Port 0 alone, 4-beat packet A0..A3.
      tick();
      beat(0, 1'b1, 1'b1, 1'b0, 64'hA0);
      #1;
      chk("p0_arb_ready", 64'(in_ready), 64'd0);
      chk("p0_arb_wrreq", 64'(fifo_wrreq), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         beat(0, 1'b1, i == 0, i == 3, 64'hA0 + 64'(i));
         #1;
         chk("p0_busy", 64'(busy), 64'd1);
         chk("p0_grant", 64'(grant_id), 64'd0);
         chk("p0_ready", 64'(in_ready), 64'b01);
         chk_wr("p0_beat", 64'hA0 + 64'(i));
      end
      tick();
      idle_all();
      #1;
      chk("p0_end_busy", 64'(busy), 64'd0);
      chk("p0_end_wrreq", 64'(fifo_wrreq), 64'd0);
      chk("p0_end_err_sop", 64'(err_sop), 64'd0);

      // Reset so contention starts from the reset last_grant (port 1).
      sclr = 1'b1;
      tick();
      sclr = 1'b0;

      tick();
      beat(0, 1'b1, 1'b1, 1'b0, 64'hC0);
      beat(1, 1'b1, 1'b1, 1'b0, 64'hD0);
      #1;
      chk("cont_arb_ready", 64'(in_ready), 64'd0);
      tick();
      #1;
      chk("cont1_grant", 64'(grant_id), 64'd0);
      chk("cont1_ready", 64'(in_ready), 64'b01);
      chk_wr("cont1_c0", 64'hC0);
      tick();
      beat(0, 1'b1, 1'b0, 1'b1, 64'hC1);
      #1;
      chk("cont1_ready_c1", 64'(in_ready), 64'b01);
      chk_wr("cont1_c1", 64'hC1);
      tick();
      beat(0, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("cont_gap_busy", 64'(busy), 64'd0);
      chk("cont_gap_ready", 64'(in_ready), 64'b00);
      chk("cont_gap_wrreq", 64'(fifo_wrreq), 64'd0);
      tick();
      #1;
      chk("cont2_grant", 64'(grant_id), 64'd1);
      chk("cont2_ready", 64'(in_ready), 64'b10);
      chk_wr("cont2_d0", 64'hD0);
      tick();
      beat(1, 1'b1, 1'b0, 1'b1, 64'hD1);
      #1;
      chk_wr("cont2_d1", 64'hD1);
      tick();
      // Second contention, single-beat packets: port 0 must win again.
      beat(0, 1'b1, 1'b1, 1'b1, 64'hE0);
      beat(1, 1'b1, 1'b1, 1'b1, 64'hF0);
      #1;
      chk("cont3_arb_wrreq", 64'(fifo_wrreq), 64'd0);
      tick();
      #1;
      chk("cont3_grant", 64'(grant_id), 64'd0);
      chk_wr("cont3_e0", 64'hE0);
      tick();
      beat(0, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("cont3_idle_busy", 64'(busy), 64'd0);
      tick();
      #1;
      chk("cont4_grant", 64'(grant_id), 64'd1);
      chk_wr("cont4_f0", 64'hF0);
      tick();
      idle_all();

      // Port 1, 3 beats, fifo_full for 3 cycles on beat 1.
      tick();
      beat(1, 1'b1, 1'b1, 1'b0, 64'h90);
      tick();
      #1;
      chk_wr("full_b0", 64'h90);
      tick();
      beat(1, 1'b1, 1'b0, 1'b0, 64'h91);
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_ready", 64'(in_ready), 64'd0);
         chk("full_wrreq", 64'(fifo_wrreq), 64'd0);
         chk("full_busy", 64'(busy), 64'd1);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("full_rel_ready", 64'(in_ready), 64'b10);
      chk_wr("full_b1", 64'h91);
      tick();
      beat(1, 1'b1, 1'b0, 1'b1, 64'h92);
      #1;
      chk_wr("full_b2", 64'h92);
      tick();
      idle_all();
      #1;
      chk("full_end_busy", 64'(busy), 64'd0);

      // Non-sop beat on port 1 while idle is dropped and flagged.
      tick();
      beat(1, 1'b1, 1'b0, 1'b0, 64'h77);
      #1;
      chk("nosop_ready", 64'(in_ready), 64'b10);
      chk("nosop_wrreq", 64'(fifo_wrreq), 64'd0);
      tick();
      idle_all();
      #1;
      chk("nosop_pulse", 64'(err_nosop), 64'b10);
      chk("nosop_busy", 64'(busy), 64'd0);
      tick();
      #1;
      chk("nosop_clear", 64'(err_nosop), 64'b00);

      // Port 0, sop repeated on beat 1 of a 3-beat packet.
      beat(0, 1'b1, 1'b1, 1'b0, 64'h50);
      tick();
      tick();
      beat(0, 1'b1, 1'b1, 1'b0, 64'h51);
      #1;
      chk("esop_none_yet", 64'(err_sop), 64'd0);
      chk_wr("esop_b1", 64'h51);
      tick();
      beat(0, 1'b1, 1'b0, 1'b1, 64'h52);
      #1;
      chk("esop_pulse", 64'(err_sop), 64'd1);
      chk_wr("esop_b2", 64'h52);
      tick();
      idle_all();
      #1;
      chk("esop_clear", 64'(err_sop), 64'd0);
      chk("cnt_p0", 64'(pkt_cnt[31:0]), STATS ? 64'd3 : 64'd0);
      chk("cnt_p1", 64'(pkt_cnt[63:32]), STATS ? 64'd3 : 64'd0);

      // sclr on beat 2 of a 5-beat packet abandons it.
      beat(0, 1'b1, 1'b1, 1'b0, 64'h30);
      tick();
      tick();
      beat(0, 1'b1, 1'b0, 1'b0, 64'h31);
      tick();
      beat(0, 1'b1, 1'b0, 1'b0, 64'h32);
      sclr = 1'b1;
      #1;
      chk("mid_rst_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_wrreq", 64'(fifo_wrreq), 64'd0);
      tick();
      sclr = 1'b0;
      beat(0, 1'b1, 1'b0, 1'b0, 64'h33);
      #1;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_wrreq", 64'(fifo_wrreq), 64'd0);
      chk("post_rst_ready", 64'(in_ready), 64'b01);
      chk("post_rst_cnt", 64'(pkt_cnt), 64'd0);
      tick();
      idle_all();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
